// File: rtl/mem_io_responder_pkg.sv
// Shared CPU memory-interface definitions: default widths, I/O page layout, responder states.
package cpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic [7:0] IO_BASE_DEF = 8'hF0;
    localparam int         IO_OUT_OFS  = 0;
    localparam int         IO_IN_OFS   = 1;

    typedef enum logic [1:0] {
        RSP_IDLE,
        RSP_WAIT,
        RSP_RESP
    } resp_state_t;

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU request/response bus between the multicycle control FSM and the memory responder.
interface mem_io_responder_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/mem_io_responder_sync2.sv
// Two-flop synchronizer for asynchronous board inputs.
module sync2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    // Shift the raw input through two flops before anyone reads it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/mem_io_responder.sv
// Memory responder: services CPU fetch/load/store from on-chip RAM or the I/O page,
// answering each accepted request with a one-cycle response after WAIT_CYCLES wait states.
module mem_io_responder
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W      = ADDR_W_DEF,
    parameter int unsigned       DATA_W      = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] IO_BASE     = ADDR_W'(IO_BASE_DEF),
    parameter int unsigned       WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_io_responder_if.slave bus,
    output logic [DATA_W-1:0] io_out,
    input  logic [DATA_W-1:0] io_in,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'(RSP_IDLE);
    localparam logic [1:0] S_WAIT = 2'(RSP_WAIT);
    localparam logic [1:0] S_RESP = 2'(RSP_RESP);

    localparam logic [ADDR_W-1:0] IO_OUT_ADDR = IO_BASE + ADDR_W'(IO_OUT_OFS);
    localparam logic [ADDR_W-1:0] IO_IN_ADDR  = IO_BASE + ADDR_W'(IO_IN_OFS);
    localparam logic [3:0]        WAIT_INIT   = 4'(WAIT_CYCLES);
    localparam int unsigned       RAM_DEPTH   = 32'(IO_BASE);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_io_out;
    logic [DATA_W-1:0] r_ram [RAM_DEPTH];

    logic              w_idle;
    logic              w_resp;
    logic              w_accept;
    logic              w_load_hit;
    logic              w_ram_commit;
    logic              w_io_commit;
    logic [DATA_W-1:0] w_io_in_sync;
    logic [DATA_W-1:0] w_rdata;

    assign w_idle       = (r_state == S_IDLE);
    assign w_resp       = (r_state == S_RESP);
    // Boot load owns the IDLE cycle, so a simultaneous CPU request is held off.
    assign w_accept     = w_idle & bus.req_valid & ~load_en;
    assign w_load_hit   = w_idle & load_en & (load_addr < IO_BASE);
    assign w_ram_commit = w_resp & r_we & (r_addr < IO_BASE);
    assign w_io_commit  = w_resp & r_we & (r_addr == IO_OUT_ADDR);

    sync2 #(.WIDTH(DATA_W)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (io_in),
        .o_q   (w_io_in_sync)
    );

    // Request FSM: latch the request on accept, count wait states, then respond once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= bus.req_addr;
                        r_we    <= bus.req_we;
                        r_wdata <= bus.req_wdata;
                        r_cnt   <= WAIT_INIT;
                        r_state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // RAM write port shared by boot load (IDLE only) and store commit (RESP edge only).
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_load_hit) begin
                r_ram[load_addr] <= load_data;
            end else if (w_ram_commit) begin
                r_ram[r_addr] <= r_wdata;
            end
        end
    end

    // LED output register, written by a store to the io_out address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_io_out <= '0;
        end else if (w_io_commit) begin
            r_io_out <= r_wdata;
        end
    end

    // Read decode over the latched address; unmapped I/O addresses read as zero.
    always_comb begin
        w_rdata = '0;
        if (r_addr < IO_BASE) begin
            w_rdata = r_ram[r_addr];
        end else if (r_addr == IO_OUT_ADDR) begin
            w_rdata = r_io_out;
        end else if (r_addr == IO_IN_ADDR) begin
            w_rdata = w_io_in_sync;
        end
    end

    assign bus.req_ready  = w_idle & ~load_en;
    assign bus.resp_valid = w_resp;
    assign bus.resp_rdata = (w_resp & ~r_we) ? w_rdata : '0;
    assign io_out         = r_io_out;
    assign busy           = ~w_idle;

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench: two responders (WAIT_CYCLES 2 and 0) sharing clock and reset.
module tb_mem_io_responder;
    import cpu_pkg::*;

    localparam int W2 = 2;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic mon_on = 1'b0;

    exp_t sb2[$];
    exp_t sb0[$];
    exp_t e2;
    exp_t e0;

    logic [7:0] io_out2, io_in2, load_addr2, load_data2;
    logic       load_en2, busy2;
    logic [7:0] io_out0, io_in0, load_addr0, load_data0;
    logic       load_en0, busy0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_io_responder_if #(.ADDR_W(8), .DATA_W(8)) bus2 ();
    mem_io_responder_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();

    mem_io_responder #(.ADDR_W(8), .DATA_W(8), .IO_BASE(8'hF0), .WAIT_CYCLES(W2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2),
        .io_out(io_out2), .io_in(io_in2),
        .load_en(load_en2), .load_addr(load_addr2), .load_data(load_data2),
        .busy(busy2)
    );

    mem_io_responder #(.ADDR_W(8), .DATA_W(8), .IO_BASE(8'hF0), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0),
        .io_out(io_out0), .io_in(io_in0),
        .load_en(load_en0), .load_addr(load_addr0), .load_data(load_data0),
        .busy(busy0)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Response monitors: every resp_valid pops the scoreboard and checks data and cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            if (bus2.resp_valid) begin
                check_val("sb2_nonempty", 32'(sb2.size() != 0), 1);
                if (sb2.size() != 0) begin
                    e2 = sb2.pop_front();
                    check_val("rdata2", bus2.resp_rdata, e2.data);
                    check_val("latency2", cyc, e2.cyc);
                    check_val("rdy_in_resp2", bus2.req_ready, 0);
                end
            end else begin
                check_val("rdata_idle2", bus2.resp_rdata, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (bus0.resp_valid) begin
                check_val("sb0_nonempty", 32'(sb0.size() != 0), 1);
                if (sb0.size() != 0) begin
                    e0 = sb0.pop_front();
                    check_val("rdata0", bus0.resp_rdata, e0.data);
                    check_val("latency0", cyc, e0.cyc);
                end
            end else begin
                check_val("rdata_idle0", bus0.resp_rdata, 0);
            end
        end
    end

    task automatic load2(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        load_en2 = 1'b1; load_addr2 = a; load_data2 = d;
        @(posedge clk); #1;
        load_en2 = 1'b0;
    endtask

    task automatic load0(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        load_en0 = 1'b1; load_addr0 = a; load_data0 = d;
        @(posedge clk); #1;
        load_en0 = 1'b0;
    endtask

    // Issue one request to dut2, push its expected response, then watch req_ready
    // through WAIT/RESP and back in IDLE. Request fields are scrambled after accept.
    task automatic req2(input logic we, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp);
        exp_t x;
        bit   got;
        @(posedge clk); #1;
        bus2.req_valid = 1'b1; bus2.req_we = we; bus2.req_addr = a; bus2.req_wdata = d;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus2.req_ready) begin
                got = 1'b1;
                x.data = exp;
                x.cyc  = cyc + 1 + W2;
                sb2.push_back(x);
            end
        end
        check_val("accept2", 32'(got), 1);
        @(posedge clk); #1;
        bus2.req_valid = 1'b0;
        bus2.req_we    = ~we;
        bus2.req_addr  = 8'($urandom);
        bus2.req_wdata = 8'($urandom);
        for (int i = 0; i < W2 + 1; i++) begin
            @(negedge clk);
            check_val("rdy_low2", bus2.req_ready, 0);
        end
        @(negedge clk);
        check_val("rdy_idle2", bus2.req_ready, 1);
    endtask

    task automatic drain2();
        for (int i = 0; i < 20 && sb2.size() != 0; i++) @(negedge clk);
        check_val("drain2", sb2.size(), 0);
    endtask

    task automatic drain0();
        for (int i = 0; i < 20 && sb0.size() != 0; i++) @(negedge clk);
        check_val("drain0", sb0.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t x;
        int   acc;
        int   acc_cyc [2];

        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
        load_en2 = 1'b0; load_addr2 = '0; load_data2 = '0; io_in2 = '0;
        load_en0 = 1'b0; load_addr0 = '0; load_data0 = '0; io_in0 = '0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        check_val("rst_busy2", busy2, 0);
        check_val("rst_ready2", bus2.req_ready, 1);
        check_val("rst_rvalid2", bus2.resp_valid, 0);
        check_val("rst_ioout2", io_out2, 0);
        check_val("rst_busy0", busy0, 0);
        check_val("rst_ready0", bus0.req_ready, 1);

        // Boot-load then read with two wait states.
        load2(8'h10, 8'hA5);
        req2(1'b0, 8'h10, 8'h00, 8'hA5);
        drain2();

        // Store then read back from RAM.
        req2(1'b1, 8'h20, 8'h3C, 8'h00);
        req2(1'b0, 8'h20, 8'h00, 8'h3C);
        drain2();

        // I/O page.
        req2(1'b1, 8'hF0, 8'h81, 8'h00);
        check_val("io_out_set", io_out2, 8'h81);
        req2(1'b0, 8'hF0, 8'h00, 8'h81);
        req2(1'b1, 8'hF1, 8'h99, 8'h00);
        check_val("io_out_keep", io_out2, 8'h81);
        io_in2 = 8'h5A;
        repeat (3) @(posedge clk);
        req2(1'b0, 8'hF1, 8'h00, 8'h5A);
        req2(1'b0, 8'hF7, 8'h00, 8'h00);
        req2(1'b1, 8'hF7, 8'h55, 8'h00);
        req2(1'b0, 8'hF0, 8'h00, 8'h81);
        drain2();

        // Boot load and request in the same IDLE cycle.
        @(posedge clk); #1;
        load_en2 = 1'b1; load_addr2 = 8'h40; load_data2 = 8'hC3;
        bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_addr = 8'h40; bus2.req_wdata = '0;
        @(negedge clk);
        check_val("rdy_during_load", bus2.req_ready, 0);
        @(posedge clk); #1;
        load_en2 = 1'b0;
        @(negedge clk);
        check_val("busy_after_load", busy2, 0);
        check_val("rdy_after_load", bus2.req_ready, 1);
        x.data = 8'hC3;
        x.cyc  = cyc + 1 + W2;
        sb2.push_back(x);
        @(posedge clk); #1;
        bus2.req_valid = 1'b0;
        drain2();

        // Boot load to an I/O address must not disturb io_out.
        load2(8'hF0, 8'h3E);
        check_val("load_io_ignored", io_out2, 8'h81);

        // Back-to-back reads with zero wait states.
        load0(8'h01, 8'h11);
        load0(8'h02, 8'h22);
        @(posedge clk); #1;
        bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_addr = 8'h01;
        acc = 0;
        for (int i = 0; i < 10 && acc < 2; i++) begin
            @(negedge clk);
            if (bus0.req_ready) begin
                acc_cyc[acc] = cyc;
                x.data = (acc == 0) ? 8'h11 : 8'h22;
                x.cyc  = cyc + 1;
                sb0.push_back(x);
                acc++;
                @(posedge clk); #1;
                bus0.req_addr = 8'h02;
            end else begin
                check_val("busy0_gap", busy0, 1);
            end
        end
        bus0.req_valid = 1'b0;
        check_val("accepts0", acc, 2);
        check_val("accept_gap0", acc_cyc[1] - acc_cyc[0], 2);
        drain0();

        // Reset during WAIT of a store: nothing commits, no response.
        load2(8'h30, 8'h11);
        @(posedge clk); #1;
        bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_addr = 8'h30; bus2.req_wdata = 8'h77;
        @(negedge clk);
        check_val("rdy_t6", bus2.req_ready, 1);
        @(posedge clk); #1;
        bus2.req_valid = 1'b0;
        @(negedge clk);
        check_val("busy_wait_t6", busy2, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("busy_after_rst", busy2, 0);
        check_val("io_out_after_rst", io_out2, 0);
        check_val("rvalid_after_rst", bus2.resp_valid, 0);
        req2(1'b0, 8'h30, 8'h00, 8'h11);
        drain2();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
